// File: rtl/resp_crossbar_pkg.sv
// Shared types and constants for the two-responder / two-initiator response crossbar.
package resp_crossbar_pkg;

   localparam int DEFAULT_WIDTH = 8;

   typedef logic port_idx_t;

   // Registered output slot; the payload field is DEFAULT_WIDTH wide.
   typedef struct packed {
      logic                     val;
      port_idx_t                src;
      logic [DEFAULT_WIDTH-1:0] data;
   } slot_t;

endpackage

// File: rtl/resp_crossbar_if.sv
// Response-side bus of the crossbar: two responder inputs (r0/r1) and two initiator outputs (q0/q1).
interface resp_crossbar_if
   import resp_crossbar_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
);

   logic             r0_val;
   logic             r1_val;
   port_idx_t        r0_dst;
   port_idx_t        r1_dst;
   logic [WIDTH-1:0] r0_data;
   logic [WIDTH-1:0] r1_data;
   logic             r0_rdy;
   logic             r1_rdy;

   logic             q0_val;
   logic             q1_val;
   port_idx_t        q0_src;
   port_idx_t        q1_src;
   logic [WIDTH-1:0] q0_data;
   logic [WIDTH-1:0] q1_data;
   logic             q0_rdy;
   logic             q1_rdy;

   modport master (
      output r0_val, r1_val, r0_dst, r1_dst, r0_data, r1_data, q0_rdy, q1_rdy,
      input  r0_rdy, r1_rdy, q0_val, q1_val, q0_src, q1_src, q0_data, q1_data
   );

   modport slave (
      input  r0_val, r1_val, r0_dst, r1_dst, r0_data, r1_data, q0_rdy, q1_rdy,
      output r0_rdy, r1_rdy, q0_val, q1_val, q0_src, q1_src, q0_data, q1_data
   );

endinterface

// File: rtl/resp_crossbar_slot.sv
// One output slot of the crossbar: arbiter between r0/r1, optional round-robin pointer
// (RESP_CROSSBAR_RR_EN) and the registered q output.
module resp_crossbar_slot
   import resp_crossbar_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH,
   parameter int K     = 0
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [1:0]       r_val,
   input  logic [1:0]       r_dst,
   input  logic [WIDTH-1:0] r_data [2],
   input  logic             q_rdy,
   output logic [1:0]       rdy,
   output logic             q_val,
   output port_idx_t        q_src,
   output logic [WIDTH-1:0] q_data
);

   localparam port_idx_t IDX = port_idx_t'(K);

   slot_t      slot_reg;
   slot_t      slot_next;
   logic [1:0] aim;
   logic [1:0] req;
   logic [1:0] acc;
   logic       free;
   logic       favour;

   assign aim[0] = (r_dst[0] == IDX);
   assign aim[1] = (r_dst[1] == IDX);
   assign req    = r_val & aim;
   assign free   = !slot_reg.val || q_rdy;

`ifdef RESP_CROSSBAR_RR_EN
   logic ptr_reg;
   logic ptr_next;

   assign favour = ptr_reg;

   // Only a contended grant moves the pointer, and always to the input that lost.
   always_comb begin
      ptr_next = ptr_reg;
      if (req[0] && req[1] && free) begin
         ptr_next = ~ptr_reg;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr_reg <= 1'b0;
      end else begin
         ptr_reg <= ptr_next;
      end
   end
`else
   assign favour = 1'b0;
`endif

   // An input loses only when the other one presents to this slot and holds the favour,
   // so each rdy is independent of its own valid.
   assign rdy[0] = rst_n && free && aim[0] && !(req[1] && favour);
   assign rdy[1] = rst_n && free && aim[1] && !(req[0] && !favour);
   assign acc    = r_val & rdy;

   always_comb begin
      slot_next = slot_reg;
      if (acc[0]) begin
         slot_next.val  = 1'b1;
         slot_next.src  = 1'b0;
         slot_next.data = DEFAULT_WIDTH'(r_data[0]);
      end else if (acc[1]) begin
         slot_next.val  = 1'b1;
         slot_next.src  = 1'b1;
         slot_next.data = DEFAULT_WIDTH'(r_data[1]);
      end else if (q_rdy) begin
         slot_next.val  = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         slot_reg <= '0;
      end else begin
         slot_reg <= slot_next;
      end
   end

   assign q_val  = slot_reg.val;
   assign q_src  = slot_reg.src;
   assign q_data = WIDTH'(slot_reg.data);

endmodule

// File: rtl/resp_crossbar.sv
// Top of the 2x2 response crossbar; one slot per initiator, optional round-robin
// arbitration selected by RESP_CROSSBAR_RR_EN (fixed r0 priority otherwise).
module resp_crossbar
   import resp_crossbar_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic           clk,
   input  logic           rst_n,
   resp_crossbar_if.slave bus
);

   logic [1:0]       r_val;
   logic [1:0]       r_dst;
   logic [WIDTH-1:0] r_data [2];
   logic [1:0]       q_rdy;
   logic [1:0]       q_val;
   logic [1:0]       q_src;
   logic [WIDTH-1:0] q_data [2];
   logic [1:0]       grant  [2];

   assign r_val     = {bus.r1_val, bus.r0_val};
   assign r_dst     = {bus.r1_dst, bus.r0_dst};
   assign r_data[0] = bus.r0_data;
   assign r_data[1] = bus.r1_data;
   assign q_rdy     = {bus.q1_rdy, bus.q0_rdy};

   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_slot
         resp_crossbar_slot #(
            .WIDTH (WIDTH),
            .K     (gi)
         ) u_slot (
            .clk    (clk),
            .rst_n  (rst_n),
            .r_val  (r_val),
            .r_dst  (r_dst),
            .r_data (r_data),
            .q_rdy  (q_rdy[gi]),
            .rdy    (grant[gi]),
            .q_val  (q_val[gi]),
            .q_src  (q_src[gi]),
            .q_data (q_data[gi])
         );
      end
   endgenerate

   // Each responder sees the grant of the slot it is addressing.
   assign bus.r0_rdy  = grant[r_dst[0]][0];
   assign bus.r1_rdy  = grant[r_dst[1]][1];

   assign bus.q0_val  = q_val[0];
   assign bus.q1_val  = q_val[1];
   assign bus.q0_src  = q_src[0];
   assign bus.q1_src  = q_src[1];
   assign bus.q0_data = q_data[0];
   assign bus.q1_data = q_data[1];

endmodule

// File: tb/tb_resp_crossbar.sv
// Scoreboard bench for resp_crossbar: directed scenarios followed by random traffic.
module tb_resp_crossbar;
   import resp_crossbar_pkg::*;

   localparam int W = 8;

   logic clk = 1'b0;
   logic rst_n;

   always #5 clk = ~clk;

   resp_crossbar_if #(.WIDTH(W)) bus();

   resp_crossbar #(.WIDTH(W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   int vectors     = 0;
   int miscompares = 0;

   // Expected beats per (responder i, initiator k), index i*2+k.
   logic [W-1:0] exp_q [4][$];
   logic [1:0]   favour;

`ifdef RESP_CROSSBAR_RR_EN
   localparam bit RR = 1'b1;
`else
   localparam bit RR = 1'b0;
`endif

   function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endfunction

   task automatic drive(input logic v0, input logic d0, input logic [W-1:0] x0,
                        input logic v1, input logic d1, input logic [W-1:0] x1,
                        input logic qr0, input logic qr1);
      bus.r0_val  = v0;
      bus.r0_dst  = d0;
      bus.r0_data = x0;
      bus.r1_val  = v1;
      bus.r1_dst  = d1;
      bus.r1_data = x1;
      bus.q0_rdy  = qr0;
      bus.q1_rdy  = qr1;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_model();
      for (int n = 0; n < 4; n++) exp_q[n].delete();
      favour = 2'b00;
   endtask

   // Called at posedge+1: pulses reset between edges.
   task automatic apply_reset();
      rst_n = 1'b0;
      clear_model();
      #2;
      rst_n = 1'b1;
      step();
   endtask

   // Monitor: at each falling edge, decide what the coming rising edge will transfer.
   initial begin
      forever begin
         @(negedge clk);
         if (rst_n === 1'b1) begin
            logic [1:0]   qv, qr, qs, rv, rd, rr, fr;
            logic [W-1:0] qd [2];
            logic [W-1:0] rx [2];
            qv = {bus.q1_val, bus.q0_val};
            qr = {bus.q1_rdy, bus.q0_rdy};
            qs = {bus.q1_src, bus.q0_src};
            qd[0] = bus.q0_data;
            qd[1] = bus.q1_data;
            rv = {bus.r1_val, bus.r0_val};
            rd = {bus.r1_dst, bus.r0_dst};
            rr = {bus.r1_rdy, bus.r0_rdy};
            rx[0] = bus.r0_data;
            rx[1] = bus.r1_data;
            for (int k = 0; k < 2; k++) begin
               int outstanding;
               outstanding = exp_q[k].size() + exp_q[2+k].size();
               check($sformatf("mon_q%0d_val", k), 32'(qv[k]), 32'(outstanding > 0));
               fr[k] = !qv[k] || qr[k];
               if (qv[k] && qr[k]) begin
                  int idx;
                  idx = int'(qs[k]) * 2 + k;
                  if (exp_q[idx].size() == 0) begin
                     check($sformatf("mon_q%0d_unexpected_src%0d", k, qs[k]), 32'(qd[k]), 32'hFFFF_FFFF);
                  end else begin
                     check($sformatf("mon_q%0d_data_src%0d", k, qs[k]), 32'(qd[k]), 32'(exp_q[idx].pop_front()));
                  end
               end
            end
            for (int i = 0; i < 2; i++) begin
               int  oth;
               bit  lose;
               oth  = 1 - i;
               lose = rv[oth] && (rd[oth] == rd[i]) && (RR ? (favour[rd[i]] == oth[0]) : (oth == 0));
               check($sformatf("mon_r%0d_rdy", i), 32'(rr[i]), 32'(fr[rd[i]] && !lose));
               if (rv[i] && rr[i]) exp_q[i*2 + int'(rd[i])].push_back(rx[i]);
            end
            if (RR && rv[0] && rv[1] && (rd[0] == rd[1]) && fr[rd[0]]) begin
               favour[rd[0]] = ~favour[rd[0]];
            end
         end
      end
   end

   initial begin
      drive(0, 0, '0, 0, 0, '0, 0, 0);
      clear_model();
      rst_n = 1'b1;
      #2;
      rst_n = 1'b0;
      #1;
      check("rst_q0_val", 32'(bus.q0_val), 0);
      check("rst_q1_val", 32'(bus.q1_val), 0);
      check("rst_q0_data", 32'(bus.q0_data), 0);
      drive(1, 0, 8'h01, 1, 1, 8'h02, 1, 1);
      #1;
      check("rst_r0_rdy", 32'(bus.r0_rdy), 0);
      check("rst_r1_rdy", 32'(bus.r1_rdy), 0);
      drive(0, 0, '0, 0, 0, '0, 0, 0);
      @(posedge clk);
      @(posedge clk);
      #3;
      rst_n = 1'b1;
      step();

      // Single beat r0 -> q1.
      drive(1, 1, 8'hA5, 0, 0, '0, 0, 1);
      #1;
      check("single_r0_rdy", 32'(bus.r0_rdy), 1);
      step();
      drive(0, 0, '0, 0, 0, '0, 1, 1);
      check("single_q1_val", 32'(bus.q1_val), 1);
      check("single_q1_src", 32'(bus.q1_src), 0);
      check("single_q1_data", 32'(bus.q1_data), 32'hA5);
      step();
      check("single_q1_cleared", 32'(bus.q1_val), 0);

      // Parallel beats to different initiators.
      drive(1, 0, 8'h11, 1, 1, 8'h22, 1, 1);
      #1;
      check("par_r0_rdy", 32'(bus.r0_rdy), 1);
      check("par_r1_rdy", 32'(bus.r1_rdy), 1);
      step();
      drive(0, 0, '0, 0, 0, '0, 1, 1);
      check("par_q0_data", 32'(bus.q0_data), 32'h11);
      check("par_q0_src", 32'(bus.q0_src), 0);
      check("par_q1_data", 32'(bus.q1_data), 32'h22);
      check("par_q1_src", 32'(bus.q1_src), 1);
      step();

      // Continuous contention on q0.
      apply_reset();
      drive(1, 0, 8'h40, 1, 0, 8'h80, 1, 0);
      for (int c = 0; c < 6; c++) begin
         logic exp_src;
         exp_src = RR ? c[0] : 1'b0;
         step();
         check($sformatf("cont_q0_src_%0d", c), 32'(bus.q0_src), 32'(exp_src));
         check($sformatf("cont_q0_data_%0d", c), 32'(bus.q0_data), exp_src ? 32'h80 : 32'h40);
         if (!RR) check($sformatf("cont_r1_rdy_%0d", c), 32'(bus.r1_rdy), 0);
      end
      drive(0, 0, '0, 0, 0, '0, 1, 1);
      step();

      // Backpressure on q0 with 0x3C held.
      drive(1, 0, 8'h3C, 0, 0, '0, 0, 1);
      #1;
      check("bp_load_r0_rdy", 32'(bus.r0_rdy), 1);
      step();
      drive(0, 0, '0, 1, 0, 8'h77, 0, 1);
      for (int c = 0; c < 4; c++) begin
         #1;
         check($sformatf("bp_hold_val_%0d", c), 32'(bus.q0_val), 1);
         check($sformatf("bp_hold_data_%0d", c), 32'(bus.q0_data), 32'h3C);
         check($sformatf("bp_hold_r1_rdy_%0d", c), 32'(bus.r1_rdy), 0);
         step();
      end
      drive(0, 0, '0, 1, 0, 8'h77, 1, 1);
      #1;
      check("bp_refill_r1_rdy", 32'(bus.r1_rdy), 1);
      step();
      drive(0, 0, '0, 0, 0, '0, 1, 1);
      check("bp_refill_data", 32'(bus.q0_data), 32'h77);
      check("bp_refill_src", 32'(bus.q0_src), 1);
      step();

      // Reset while both slots are full.
      drive(1, 0, 8'h5A, 1, 1, 8'h6B, 0, 0);
      step();
      drive(0, 0, '0, 0, 0, '0, 0, 0);
      #1;
      check("mid_full_q0", 32'(bus.q0_val), 1);
      check("mid_full_q1", 32'(bus.q1_val), 1);
      rst_n = 1'b0;
      clear_model();
      #1;
      check("mid_rst_q0_val", 32'(bus.q0_val), 0);
      check("mid_rst_q1_val", 32'(bus.q1_val), 0);
      check("mid_rst_q1_data", 32'(bus.q1_data), 0);
      drive(1, 0, 8'h99, 1, 1, 8'h98, 1, 1);
      #1;
      check("mid_rst_r0_rdy", 32'(bus.r0_rdy), 0);
      check("mid_rst_r1_rdy", 32'(bus.r1_rdy), 0);
      drive(0, 0, '0, 0, 0, '0, 1, 1);
      rst_n = 1'b1;
      step();
      step();
      check("post_rst_q0_val", 32'(bus.q0_val), 0);
      check("post_rst_q1_val", 32'(bus.q1_val), 0);
      drive(1, 1, 8'hC1, 1, 1, 8'hC2, 1, 1);
      #1;
      check("post_rst_ptr_r0_rdy", 32'(bus.r0_rdy), 1);
      check("post_rst_ptr_r1_rdy", 32'(bus.r1_rdy), 0);
      step();
      drive(0, 0, '0, 0, 0, '0, 1, 1);
      check("post_rst_ptr_src", 32'(bus.q1_src), 0);
      step();

      // Random traffic checked by the monitor.
      for (int n = 0; n < 400; n++) begin
         drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), W'($urandom),
               1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), W'($urandom),
               1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 3) != 0));
         step();
      end
      drive(0, 0, '0, 0, 0, '0, 1, 1);
      repeat (4) step();
      check("drain_empty", 32'(exp_q[0].size() + exp_q[1].size() + exp_q[2].size() + exp_q[3].size()), 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/resp_crossbar.md
RESP_CROSSBAR -- requirements
Module: resp_crossbar

Interface
REQ-001 SHALL have parameter: WIDTH, 8, payload width in bits.
REQ-002 SHALL have port: clk  input  1  rising-edge clock.
REQ-003 SHALL have port: rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have ports: r0_val / r1_val  input  1  response valid from responder 0/1.
REQ-005 SHALL have ports: r0_dst / r1_dst  input  1  destination initiator index (the original src tag).
REQ-006 SHALL have ports: r0_data / r1_data  input  WIDTH  response payload.
REQ-007 SHALL have ports: r0_rdy / r1_rdy  output  1  response accepted this cycle when high with r_val.
REQ-008 SHALL have ports: q0_val / q1_val  output  1  response valid toward initiator 0/1.
REQ-009 SHALL have ports: q0_src / q1_src  output  1  index of the responder that produced the payload.
REQ-010 SHALL have ports: q0_data / q1_data  output  WIDTH  payload toward initiator 0/1.
REQ-011 SHALL have ports: q0_rdy / q1_rdy  input  1  initiator 0/1 accepts q payload.

Function
REQ-012 SHALL hold one registered slot per output q0/q1 (val, src, data); all q outputs SHALL be driven from these registers only.
REQ-013 SHALL transfer on r side when r_val and r_rdy are both high at a rising edge, and on q side when q_val and q_rdy are both high.
REQ-014 SHALL route an accepted r_i beat to slot q[r_i_dst], with q_src = i; latency r-accept to q_val = 1 cycle.
REQ-015 SHALL treat slot k as free when q_k_val=0 or (q_k_val=1 and q_k_rdy=1): a same-cycle drain and refill SHALL sustain 1 beat/cycle per output.
REQ-016 SHALL compute r_i_rdy combinationally = (slot[r_i_dst] free) and (r_i wins arbitration for that slot); r_i_rdy SHALL NOT depend on r_i_val.
REQ-017 SHALL arbitrate only when r0_val=r1_val=1 and r0_dst=r1_dst; otherwise each valid input wins its own slot, so both inputs SHALL be accepted in the same cycle when dst differ and both slots are free.
REQ-018 SHALL keep q_val, q_src, q_data stable while q_val=1 and q_rdy=0; a loser SHALL keep r_rdy=0 and retry without loss.
REQ-019 SHALL clear q_k_val after a q_k drain with no refill in the same cycle.
REQ-020 SHALL not drop, duplicate, or reorder beats from one responder to one initiator.

Reset
REQ-021 SHALL on rst_n low, asynchronously: q0_val=q1_val=0, q0_src=q1_src=0, q0_data=q1_data=0, arbitration pointers=0.
REQ-022 SHALL keep r0_rdy=r1_rdy=0 while rst_n is low; the first acceptance SHALL be possible at the first rising edge after deassertion.
REQ-023 SHALL discard slot contents when reset is asserted mid-transfer; no beat SHALL be presented after reset until a new r-accept.

Configuration
REQ-024 SHALL use the macro RESP_CROSSBAR_RR_EN: when defined, each slot has a 1-bit round-robin pointer (favoured input); on a contended grant the pointer SHALL move to the non-granted input.
REQ-025 SHALL without RESP_CROSSBAR_RR_EN use fixed priority, with r0 always winning contention and no pointer state.

Structure
REQ-026 SHALL place in shared package resp_crossbar_pkg: default WIDTH constant, 1-bit port-index typedef, slot struct typedef (val, src, data).
REQ-027 SHALL implement one sub-module resp_crossbar_slot (arbiter, pointer, output register) instantiated twice, k=0 and k=1.

Verification
REQ-028 SHALL cover single beat: r0 val, dst=1, data=0xA5, q1_rdy=1 -> next cycle q1_val=1, q1_src=0, q1_data=0xA5; r0_rdy=1 in the accept cycle.
REQ-029 SHALL cover parallel beats: r0 dst=0 data=0x11, r1 dst=1 data=0x22, same cycle -> both rdy=1; next cycle q0=0x11 src=0 and q1=0x22 src=1.
REQ-030 SHALL cover contention: r0 and r1 both dst=0, continuous, q0_rdy=1 -> with RR: q0_src alternates 0,1,0,1; without RR: r0 always wins and r1_rdy stays 0.
REQ-031 SHALL cover backpressure: q0_rdy=0 for 4 cycles with slot full (0x3C) -> q0 holds 0x3C, r_rdy for dst=0 stays 0; q0_rdy=1 -> drain and refill in the same cycle.
REQ-032 SHALL cover reset mid-operation: both slots full, rst_n pulsed low between edges -> q0_val=q1_val=0 immediately; pointers=0; no stale beat after release.
